// File: rtl/controlador_deslocamento_pkg.sv
// Shared definitions for the shift-register sequencer: state encoding,
// default word width and counter width helper.
package controlador_deslocamento_pkg;

  localparam int unsigned LARGURA_PADRAO = 4;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] DESLOCA = 2'd1;
  localparam logic [1:0] CONCLUI = 2'd2;

  // Bits needed to count 0..WIDTH-1
  function automatic int unsigned largura_contagem(input int unsigned largura);
    return $clog2(largura);
  endfunction

endpackage

// File: rtl/controlador_deslocamento_if.sv
// Request/serial bus between a word producer and the shift-register sequencer.
interface controlador_deslocamento_if
  import controlador_deslocamento_pkg::*;
#(
  parameter int unsigned WIDTH = LARGURA_PADRAO
) ();

  localparam int unsigned CW = largura_contagem(WIDTH);

  logic             inicio;
  logic [WIDTH-1:0] dado;
  logic             cancela;
  logic             entrada_serial;
  logic             pronto;
  logic             ocupado;
  logic             palavra_valida;
  logic [CW-1:0]    contagem;

  modport master (
    output inicio, dado, cancela,
    input  entrada_serial, pronto, ocupado, palavra_valida, contagem
  );

  modport slave (
    input  inicio, dado, cancela,
    output entrada_serial, pronto, ocupado, palavra_valida, contagem
  );

endinterface

// File: rtl/controlador_deslocamento.sv
// Serialises an accepted parallel word LSB-first into a WIDTH-stage shift
// register and flags the cycle in which the register holds the whole word.
module controlador_deslocamento
  import controlador_deslocamento_pkg::*;
#(
  parameter int unsigned WIDTH        = LARGURA_PADRAO,
  parameter logic        VALOR_OCIOSO = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  controlador_deslocamento_if.slave   bus
);

  localparam int unsigned CW = largura_contagem(WIDTH);

  logic [1:0]       estado_q,   estado_d;
  logic [WIDTH-1:0] buffer_q,   buffer_d;
  logic [CW-1:0]    contagem_q, contagem_d;
  logic             pronto_c;
  logic             aceita_c;

  assign pronto_c = (estado_q == OCIOSO) || (estado_q == CONCLUI);
  // cancela blocks acceptance even when ready
  assign aceita_c = bus.inicio && pronto_c && !bus.cancela;

  always_comb begin
    estado_d   = estado_q;
    buffer_d   = buffer_q;
    contagem_d = contagem_q;
    case (estado_q)
      OCIOSO: begin
        if (aceita_c) begin
          buffer_d   = bus.dado;
          contagem_d = '0;
          estado_d   = DESLOCA;
        end
      end
      DESLOCA: begin
        if (bus.cancela) begin
          buffer_d   = '0;
          contagem_d = '0;
          estado_d   = OCIOSO;
        end else begin
          buffer_d = buffer_q >> 1;
          if (contagem_q == CW'(WIDTH - 1)) begin
            contagem_d = '0;
            estado_d   = CONCLUI;
          end else begin
            contagem_d = contagem_q + CW'(1);
          end
        end
      end
      CONCLUI: begin
        contagem_d = '0;
        if (aceita_c) begin
          buffer_d = bus.dado;
          estado_d = DESLOCA;
        end else begin
          estado_d = OCIOSO;
        end
      end
      default: begin
        buffer_d   = '0;
        contagem_d = '0;
        estado_d   = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      buffer_q   <= '0;
      contagem_q <= '0;
    end else begin
      estado_q   <= estado_d;
      buffer_q   <= buffer_d;
      contagem_q <= contagem_d;
    end
  end

  // Outputs decoded from registered state so reset takes effect at once
  always_comb begin
    bus.entrada_serial = VALOR_OCIOSO;
    bus.pronto         = pronto_c;
    bus.ocupado        = 1'b0;
    bus.palavra_valida = 1'b0;
    bus.contagem       = contagem_q;
    if (estado_q == DESLOCA) begin
      bus.entrada_serial = buffer_q[0];
      bus.ocupado        = 1'b1;
    end
    if (estado_q == CONCLUI) begin
      bus.palavra_valida = 1'b1;
    end
  end

endmodule

// File: tb/tb_controlador_deslocamento.sv
// Directed bench: sequencer driving a 4-stage serial-in register as its load.
module tb_controlador_deslocamento;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   ciclo;
  int   t1;
  int   t2;
  logic viu_pulso;

  logic reg_a, reg_b, reg_c, reg_d;

  controlador_deslocamento_if #(.WIDTH(4)) bus ();

  controlador_deslocamento #(.WIDTH(4), .VALOR_OCIOSO(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Downstream 4-stage register A..D sharing the controller reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_a <= 1'b0; reg_b <= 1'b0; reg_c <= 1'b0; reg_d <= 1'b0;
    end else begin
      reg_a <= bus.entrada_serial; reg_b <= reg_a; reg_c <= reg_b; reg_d <= reg_c;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called right after the accept edge; ends in the palavra_valida cycle
  task automatic shift_and_check(input string tag, input logic [3:0] w, input int pulse_at);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_serial%0d", tag, i), 32'(bus.entrada_serial), 32'(w[i]));
      chk($sformatf("%s_cnt%0d", tag, i), 32'(bus.contagem), 32'(i));
      chk($sformatf("%s_ocup%0d", tag, i), 32'(bus.ocupado), 32'(1));
      chk($sformatf("%s_pv%0d", tag, i), 32'(bus.palavra_valida), 32'(0));
      if (pulse_at >= 0) begin
        bus.inicio = (i == pulse_at);
        bus.dado   = 4'b0000;
      end
      tick();
    end
    if (pulse_at >= 0) bus.inicio = 1'b0;
    chk({tag, "_pv"}, 32'(bus.palavra_valida), 32'(1));
    chk({tag, "_pronto"}, 32'(bus.pronto), 32'(1));
    chk({tag, "_reg"}, 32'({reg_a, reg_b, reg_c, reg_d}), 32'(w));
  endtask

  initial begin
    checks = 0; errors = 0; ciclo = 0;
    reset = 1'b1;
    bus.inicio = 1'b0; bus.dado = '0; bus.cancela = 1'b0;
    #3;
    chk("rst_pronto", 32'(bus.pronto), 32'(1));
    chk("rst_ocupado", 32'(bus.ocupado), 32'(0));
    chk("rst_pv", 32'(bus.palavra_valida), 32'(0));
    chk("rst_serial", 32'(bus.entrada_serial), 32'(0));
    chk("rst_cnt", 32'(bus.contagem), 32'(0));
    tick();
    reset = 1'b0;
    tick();

    // 1: single word 1011, dado changes after accept are ignored
    bus.inicio = 1'b1; bus.dado = 4'b1011;
    tick();
    bus.inicio = 1'b0; bus.dado = 4'b0000;
    shift_and_check("t1", 4'b1011, -1);
    tick();
    chk("t1_idle_pv", 32'(bus.palavra_valida), 32'(0));
    chk("t1_idle_ocup", 32'(bus.ocupado), 32'(0));

    // 2: back-to-back with inicio held
    bus.inicio = 1'b1; bus.dado = 4'b0110;
    tick();
    bus.dado = 4'b1001;
    shift_and_check("t2a", 4'b0110, -1);
    t1 = ciclo;
    tick();
    bus.inicio = 1'b0; bus.dado = 4'b0000;
    shift_and_check("t2b", 4'b1001, -1);
    t2 = ciclo;
    chk("t2_period", 32'(t2 - t1), 32'(5));
    tick();
    chk("t2_idle_pv", 32'(bus.palavra_valida), 32'(0));

    // 3: cancel at contagem == 2
    bus.inicio = 1'b1; bus.dado = 4'b1111;
    tick();
    bus.inicio = 1'b0;
    tick();
    tick();
    chk("t3_cnt2", 32'(bus.contagem), 32'(2));
    bus.cancela = 1'b1;
    tick();
    bus.cancela = 1'b0;
    chk("t3_ocup", 32'(bus.ocupado), 32'(0));
    chk("t3_pronto", 32'(bus.pronto), 32'(1));
    chk("t3_serial", 32'(bus.entrada_serial), 32'(0));
    chk("t3_cnt", 32'(bus.contagem), 32'(0));
    viu_pulso = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.palavra_valida) viu_pulso = 1'b1;
      tick();
    end
    chk("t3_no_pv", 32'(viu_pulso), 32'(0));

    // 4: cancela and inicio together in idle
    bus.cancela = 1'b1; bus.inicio = 1'b1; bus.dado = 4'b1010;
    tick();
    chk("t4_pronto", 32'(bus.pronto), 32'(1));
    chk("t4_ocup", 32'(bus.ocupado), 32'(0));
    tick();
    chk("t4_ocup2", 32'(bus.ocupado), 32'(0));
    bus.cancela = 1'b0; bus.inicio = 1'b0;

    // 5: async reset between edges mid-shift, then a clean word
    bus.inicio = 1'b1; bus.dado = 4'b1100;
    tick();
    bus.inicio = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_pronto", 32'(bus.pronto), 32'(1));
    chk("t5_ocup", 32'(bus.ocupado), 32'(0));
    chk("t5_pv", 32'(bus.palavra_valida), 32'(0));
    chk("t5_serial", 32'(bus.entrada_serial), 32'(0));
    chk("t5_cnt", 32'(bus.contagem), 32'(0));
    chk("t5_reg", 32'({reg_a, reg_b, reg_c, reg_d}), 32'(0));
    #2;
    reset = 1'b0;
    tick();
    bus.inicio = 1'b1; bus.dado = 4'b0101;
    tick();
    bus.inicio = 1'b0;
    shift_and_check("t5w", 4'b0101, -1);
    tick();

    // 6: inicio with dado 0000 while busy is ignored
    bus.inicio = 1'b1; bus.dado = 4'b1100;
    tick();
    bus.inicio = 1'b0;
    shift_and_check("t6", 4'b1100, 1);
    tick();
    chk("t6_idle_ocup", 32'(bus.ocupado), 32'(0));
    chk("t6_idle_pv", 32'(bus.palavra_valida), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
